mod_fetch_ctrl: RTL
===================

Name: mod_fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the architectural PC register.
- Issues instruction-memory requests with a req/ready handshake and applies redirects: exception, eret, and the next-PC unit's branch/jump/jr target (npc_on/pc_next).
- Honours the hazard-unit stall and MIPS delay-slot semantics.
- Drives the IF/ID register contents: pc_now, ins, valid, and flush.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_4180, fetch address on exception or misaligned redirect.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold IF/ID contents, issue no new fetch.
- npc_on  in  1  next-PC unit: redirect valid (branch taken / j / jal / jr / jalr).
- pc_next  in  32  next-PC unit redirect target.
- exc_req  in  1  exception/interrupt taken this cycle.
- eret  in  1  return from exception.
- epc  in  32  eret target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  fetch complete this cycle; imem_rdata valid.
- imem_rdata  in  32  fetched word.
- pc_now  out  32  address of the word in ins.
- ins  out  32  IF/ID instruction.
- ins_valid  out  1  ins/pc_now hold a real instruction.
- flush_ifid  out  1  one-cycle pulse: IF/ID contents squashed.
- fetch_adel  out  1  one-cycle pulse: misaligned redirect target detected.

Behaviour:
- Reset values (async, rst_n=0): state=BOOT, fetch PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, pc_now=0, ins=0, ins_valid=0, flush_ifid=0, fetch_adel=0, pending redirect cleared.
- Reset mid-transaction abandons the outstanding request; the memory's late imem_ready is ignored while in BOOT.

States:
- BOOT: one cycle after reset release, imem_req=0, then go to REQ.
- REQ: imem_req=1, imem_addr=fetch PC. On imem_ready: capture the word, stay in REQ. Otherwise go to WAIT.
- WAIT: imem_req=1, imem_addr held. On imem_ready: capture the word and go to REQ, or to HOLD if stall=1.
- HOLD: imem_req=0 while stall=1. Go to REQ the cycle after stall drops.

Capture and stall:
- Capture on the edge ending a cycle with imem_req & imem_ready: ins<=imem_rdata, pc_now<=imem_addr, ins_valid<=1.
- Latency is request-to-ins_valid 1 cycle at zero wait states; throughput is 1 instruction/cycle.
- stall=1 with ins_valid=1: ins, pc_now, ins_valid and fetch PC all hold.
- In REQ with stall=1: imem_req=0 and go to HOLD.
- In WAIT with stall=1: the outstanding request is not withdrawn; the captured word is held until stall drops.

Next-fetch-address priority, evaluated each cycle:
1. exc_req
2. eret
3. npc_on & ~stall
4. fetch PC + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0)

Redirect rules:
- exc_req: overrides stall. flush_ifid=1 next cycle, ins_valid<=0, fetch PC<=EXC_VECTOR.
  - If in WAIT, the in-flight word is discarded on arrival, then EXC_VECTOR is fetched.
- eret: same squash behaviour with target epc.
- npc_on (delay slot): the fetch at branch PC+4 is not squashed; the next fetch after it uses pc_next.
  - If the delay-slot fetch is still in WAIT, pc_next is latched into the pending register and used after that fetch completes.
  - A later npc_on before the pending target is consumed is ignored.
- Misaligned target (pc_next[1:0]!=0 or epc[1:0]!=0): fetch_adel pulses 1 cycle and the target is replaced by EXC_VECTOR.
  - npc_on case: delay slot kept.
  - eret case: squash as for eret.
- Simultaneous exc_req and npc_on: exception wins; the pending redirect is cleared.

Test Plan:
- Reset, imem_ready tied 1 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; ins_valid=1 from the 3rd cycle after rst_n rises; pc_now trails imem_addr by 1 cycle.
- npc_on=1, pc_next=0x3100 while ID holds 0x3004 (0x3008 being fetched) -> 0x3008 captured as delay slot, next imem_addr=0x3100, flush_ifid stays 0.
- imem_ready low 3 cycles during fetch of 0x3008, npc_on pulsed in the 1st wait cycle with target 0x3200 -> imem_addr held at 0x3008, then 0x3200.
- stall=1 for 2 cycles with ins=word@0x300C -> ins/pc_now unchanged, imem_req=0, fetch resumes at 0x3010; npc_on during stall is ignored.
- exc_req during WAIT -> flush_ifid 1 cycle, arriving word discarded (ins_valid=0), next imem_addr=0x4180; same-cycle npc_on ignored.
- npc_on with pc_next=0x3102 -> fetch_adel pulse, delay slot kept, then imem_addr=0x4180; eret with epc=0x3020 -> squash, imem_addr=0x3020; rst_n low mid-WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/mod_fetch_ctrl.sv
// Fetch-stage sequencer: owns the architectural PC, runs the instruction-memory
// req/ready handshake, applies exception/eret/branch redirects and drives IF/ID.
module mod_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        npc_on,
  input  logic [31:0] pc_next,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_now,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic        flush_ifid,
  output logic        fetch_adel
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_now_q, pc_now_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        adel_q, adel_d;
  logic        redir_v_q, redir_v_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        drop_q, drop_d;
  logic        hw_v_q, hw_v_d;
  logic [31:0] hw_q, hw_d;

  logic        squash;
  logic [31:0] sq_tgt;
  logic        sq_adel;
  logic        br_take;
  logic        br_mis;
  logic [31:0] br_tgt;
  logic        br_adel;
  logic        fire;
  logic [31:0] seq_next;

  assign squash  = exc_req | eret;
  assign sq_adel = ~exc_req & eret & (epc[1:0] != 2'b00);
  assign sq_tgt  = (exc_req || sq_adel) ? EXC_VECTOR : epc;

  // A branch is accepted only when no redirect is already pending: the first
  // target wins until the delay-slot fetch completes and consumes it.
  assign br_take = npc_on & ~stall & ~squash & ~redir_v_q;
  assign br_mis  = (pc_next[1:0] != 2'b00);
  assign br_tgt  = br_mis ? EXC_VECTOR : pc_next;
  assign br_adel = br_take & br_mis;

  assign imem_req  = ((state_q == S_REQ) & ~stall & ~squash) | (state_q == S_WAIT);
  assign imem_addr = pc_q;
  assign fire      = imem_req & imem_ready;
  assign seq_next  = redir_v_q ? redir_pc_q : (br_take ? br_tgt : pc_q + 32'd4);

  assign pc_now     = pc_now_q;
  assign ins        = ins_q;
  assign ins_valid  = valid_q;
  assign flush_ifid = flush_q;
  assign fetch_adel = adel_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    pc_now_d   = pc_now_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    adel_d     = br_adel | sq_adel;
    redir_v_d  = redir_v_q;
    redir_pc_d = redir_pc_q;
    drop_d     = drop_q;
    hw_v_d     = hw_v_q;
    hw_d       = hw_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (br_take) begin
          redir_v_d  = 1'b1;
          redir_pc_d = br_tgt;
        end
      end
      S_REQ: begin
        if (fire) begin
          ins_d     = imem_rdata;
          pc_now_d  = pc_q;
          valid_d   = 1'b1;
          pc_d      = seq_next;
          redir_v_d = 1'b0;
        end else if (stall) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
          if (br_take) begin
            redir_v_d  = 1'b1;
            redir_pc_d = br_tgt;
          end
        end
      end
      S_WAIT: begin
        if (imem_ready) begin
          if (drop_q) begin
            pc_d      = redir_pc_q;
            redir_v_d = 1'b0;
            drop_d    = 1'b0;
            state_d   = S_REQ;
          end else if (stall) begin
            // IF/ID is frozen: park the word; the PC advances when it is released.
            hw_d    = imem_rdata;
            hw_v_d  = 1'b1;
            state_d = S_HOLD;
          end else begin
            ins_d     = imem_rdata;
            pc_now_d  = pc_q;
            valid_d   = 1'b1;
            pc_d      = seq_next;
            redir_v_d = 1'b0;
            state_d   = S_REQ;
          end
        end else if (br_take) begin
          redir_v_d  = 1'b1;
          redir_pc_d = br_tgt;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          state_d = S_REQ;
          if (hw_v_q) begin
            ins_d     = hw_q;
            pc_now_d  = pc_q;
            valid_d   = 1'b1;
            pc_d      = seq_next;
            redir_v_d = 1'b0;
            hw_v_d    = 1'b0;
          end else if (br_take) begin
            redir_v_d  = 1'b1;
            redir_pc_d = br_tgt;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase

    // Squash overrides everything above, including stall. An in-flight request
    // cannot be withdrawn, so its word is dropped and the target applied after.
    if (squash) begin
      flush_d  = 1'b1;
      valid_d  = 1'b0;
      ins_d    = ins_q;
      pc_now_d = pc_now_q;
      hw_v_d   = 1'b0;
      if ((state_q == S_WAIT) && !imem_ready) begin
        pc_d       = pc_q;
        redir_v_d  = 1'b1;
        redir_pc_d = sq_tgt;
        drop_d     = 1'b1;
        state_d    = S_WAIT;
      end else begin
        pc_d      = sq_tgt;
        redir_v_d = 1'b0;
        drop_d    = 1'b0;
        state_d   = S_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      ins_q      <= '0;
      pc_now_q   <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      adel_q     <= 1'b0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
      drop_q     <= 1'b0;
      hw_v_q     <= 1'b0;
      hw_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      pc_now_q   <= pc_now_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      adel_q     <= adel_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
      drop_q     <= drop_d;
      hw_v_q     <= hw_v_d;
      hw_q       <= hw_d;
    end
  end

endmodule
